// File: rtl/mult4_seq_ctrl.sv
// Sequential shift-add 4x4 unsigned multiplier: one partial-product add per cycle
// through a single shared 4-bit adder, 8-bit result after four iterations.

module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    assign {c_out, s} = {1'b0, a} + {1'b0, b} + {4'b0, c_in};
endmodule

module mult4_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    logic [3:0] mcand;
    // Bit 8 of the {carry, hi, lo} accumulator is always zero after the
    // right shift, so only bits [7:0] are stored.
    logic [7:0] acc;
    logic [1:0] cnt;

    logic [3:0] add_b;
    logic [3:0] sum;
    logic       c_out;
    logic [7:0] acc_next;

    assign add_b = acc[0] ? mcand : 4'b0;

    adder4 u_add (
        .a    (acc[7:4]),
        .b    (add_b),
        .c_in (1'b0),
        .s    (sum),
        .c_out(c_out)
    );

    // {c_out, sum, acc[3:0]} shifted right by one, low bit falls off
    assign acc_next = {c_out, sum, acc[3:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= 4'h0;
            acc     <= 8'h00;
            cnt     <= 2'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= 8'h00;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= a;
                        acc   <= {4'h0, b};
                        cnt   <= 2'd0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        product <= acc_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// Scoreboard bench for mult4_seq_ctrl: driver queues expected products with
// their due cycle, a negedge monitor pops and checks on every done pulse.

module tb_mult4_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] a = 4'h0;
    logic [3:0] b = 4'h0;
    logic       busy;
    logic       done;
    logic [7:0] product;

    typedef struct {
        logic [7:0] p;
        int         c;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic prev_done = 1'b0;

    mult4_seq_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .product(product)
    );

    always #5 clk = ~clk;

    // cyc equals the number of rising edges seen, as observed at the negedge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (prev_done)
            chk("done_single_cycle", int'(done), 0);
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("product", int'(product), int'(e.p));
                chk("done_latency", cyc, e.c);
            end
        end
        prev_done <= done;
    end

    // Start accepted at the next rising edge N; done is due at the negedge after N+4.
    task automatic issue(input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp);
        @(negedge clk);
        start = 1'b1;
        a = x;
        b = y;
        q.push_back('{exp, cyc + 5});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 12) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            chk({name, "_timeout"}, q.size(), 0);
            q.delete();
        end
    endtask

    initial begin
        // Reset and idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_product", int'(product), 0);
        repeat (5) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_product", int'(product), 0);

        // Corner operands
        issue(4'd15, 4'd15, 8'hE1);
        @(negedge clk);
        chk("busy_in_run", int'(busy), 1);
        wait_empty("op_15x15");
        @(negedge clk);
        chk("product_held", int'(product), 8'hE1);
        issue(4'd0, 4'd9, 8'h00);
        wait_empty("op_0x9");
        issue(4'd13, 4'd11, 8'h8F);
        wait_empty("op_13x11");

        // Start during RUN is ignored
        issue(4'd3, 4'd5, 8'h0F);
        @(posedge clk);
        #1 start = 1'b1;
        a = 4'd15;
        b = 4'd15;
        @(posedge clk);
        #1 start = 1'b0;
        wait_empty("start_in_run");
        repeat (8) @(negedge clk);
        chk("start_in_run_idle", int'(busy), 0);

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1;
        a = 4'd7;
        b = 4'd6;
        q.push_back('{8'h2A, cyc + 5});
        q.push_back('{8'h51, cyc + 10});
        @(posedge clk);
        #1 a = 4'd9;
        b = 4'd9;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("b2b_busy", int'(busy), (k < 5) ? 1 : 0);
        end
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("b2b_busy_second", int'(busy), 1);
        wait_empty("back_to_back");

        // Reset in RUN cycle 3 aborts and clears product
        @(negedge clk);
        start = 1'b1;
        a = 4'd12;
        b = 4'd12;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_product", int'(product), 0);
        repeat (6) @(negedge clk);
        issue(4'd2, 4'd3, 8'h06);
        wait_empty("after_abort");

        // Full operand sweep against a*b
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) begin
                issue(4'(x), 4'(y), 8'(x * y));
                wait_empty("sweep");
            end

        repeat (8) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
